clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Enable controller for the `clk_gate` cell: decides cycle by cycle whether a downstream clock domain's gate is open. Its outputs drive the gate's `e_i`/`te_i` pins. It opens the gate on request, tells the requester when the gated clock is stable, and closes the gate after a programmable idle period. It sits in the free-running clock domain next to each `clk_gate` instance.

## Interface
- IDLE_CYCLES, 16, consecutive idle cycles before the gate closes; legal range ≥1.
- WAKE_CYCLES, 2, cycles between `en_o` rising and `ack_o` rising; legal range ≥0.
- CNT_W, 32, width of the statistics counter (used only under the macro).
- clk_i  in  1  free-running clock (ungated side).
- arst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  level request for the gated clock.
- busy_i  in  1  downstream logic still active; blocks closing.
- test_mode_i  in  1  DFT test enable.
- en_o  out  1  to `clk_gate.e_i`; registered.
- te_o  out  1  to `clk_gate.te_i`.
- ack_o  out  1  gated clock is running and stable.
- gated_cycles_o  out  CNT_W  cycles spent gated (present only under the macro).

## Operation
- The FSM has four states: OFF, WAKE, ON, DRAIN. The wake condition is `wk = req_i | busy_i`.
- Reset places the FSM in OFF: `en_o=0`, `ack_o=0`, counters = 0.
- OFF: `en_o=0`, `ack_o=0`.
  - `wk=1` → WAKE and loads the wake counter with WAKE_CYCLES.
  - If WAKE_CYCLES=0, `wk=1` goes directly to ON.
- WAKE: `en_o=1`, `ack_o=0`.
  - The counter decrements each cycle; at 0 the FSM goes to ON.
  - Inputs are ignored in WAKE; a wake is never aborted.
- ON: `en_o=1`, `ack_o=1`.
  - `wk=0` → DRAIN with idle count = 1.
- DRAIN: `en_o=1`, `ack_o=1`.
  - `wk=1` → ON and clears the idle count.
  - Otherwise the idle count increments.
  - When the count reaches IDLE_CYCLES, the FSM goes to OFF.
- `te_o = test_mode_i`, combinational passthrough with no register.
- `ack_o = fsm_ack | test_mode_i`, because the clock always runs in test mode. The FSM keeps operating normally in test mode.
- Counters are sized by `$clog2` of their parameter plus 1 and never wrap.

## Timing
- Wake latency: `wk` first high in cycle N.
  - `en_o` is high from N+1.
  - `ack_o` is high from N+1+WAKE_CYCLES.
- Close latency: `wk` low starting in cycle M while in ON.
  - `en_o` and `ack_o` are low from M+IDLE_CYCLES.
- A single `wk` pulse during DRAIN restarts the full IDLE_CYCLES window.
- `wk=1` in the cycle the FSM enters OFF causes OFF→WAKE on the next edge. The minimum gated time is 1 cycle.
- `en_o` only changes on `clk_i` rising edges. `clk_gate` latches it while the clock is low, so no glitch is possible.
- Asynchronous reset mid-WAKE or mid-DRAIN forces OFF immediately: `en_o=0`, `ack_o=0`.

## Configuration
- Macro `CLK_GATE_CTRL_STATS_EN`.
- Defined:
  - `gated_cycles_o` exists.
  - It increments once per cycle spent in OFF and saturates at all-ones.
  - Reset value is 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `clk_gate_ctrl_pkg`:
  - typedef `clk_gate_ctrl_state_e` (OFF, WAKE, ON, DRAIN), 2-bit enum.
  - Constants `CLK_GATE_CTRL_IDLE_DEF=16` and `CLK_GATE_CTRL_WAKE_DEF=2`.
- One sub-module, `sat_counter`: parameterised width, saturating increment, clear. It is used for `gated_cycles_o`.
- The controller does not instantiate `clk_gate`; the parent connects `en_o` and `te_o` to it.

## Test plan
All scenarios use IDLE_CYCLES=4 and WAKE_CYCLES=2 unless noted.
- Reset, then `req_i=1` in cycle 5 → `en_o=1` at 6, `ack_o=1` at 8.
- In ON, drop `req_i` and `busy_i` in cycle 20 → `en_o=0` and `ack_o=0` at 24. With the macro, `gated_cycles_o` then counts up from 0.
- In DRAIN, pulse `busy_i` in cycle 22 with idle from 20 → the gate stays open; `en_o` falls at 27.
- WAKE_CYCLES=0, `req_i` high in cycle 3 → `en_o=1` and `ack_o=1` both at 4.
- `test_mode_i=1` while OFF → `te_o=1` and `ack_o=1` the same cycle; `en_o` stays 0.
- Assert `arst_ni=0` during WAKE → `en_o=0` and `ack_o=0` immediately. After release, the FSM is in OFF and `gated_cycles_o=0`.

Source files
------------

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared state encoding and default timing parameters for the clock-gate enable controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } clk_gate_ctrl_state_e;

    localparam int unsigned CLK_GATE_CTRL_IDLE_DEF = 16;
    localparam int unsigned CLK_GATE_CTRL_WAKE_DEF = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; 1-cycle update latency.
// No backpressure: increments are dropped once the count holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable FSM: en_o 1 cycle after wake, ack_o WAKE_CYCLES later, close after IDLE_CYCLES idle.
// No backpressure; busy_i holds the gate open. CLK_GATE_CTRL_STATS_EN adds gated_cycles_o.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = CLK_GATE_CTRL_IDLE_DEF,
    parameter int unsigned WAKE_CYCLES = CLK_GATE_CTRL_WAKE_DEF
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             req_i,
    input  logic             busy_i,
    input  logic             test_mode_i,
    output logic             en_o,
    output logic             te_o,
    output logic             ack_o
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] gated_cycles_o
`endif
);

    localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES) + 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES) + 1;

    clk_gate_ctrl_state_e state_q, state_d;
    logic [WAKE_W-1:0]    wake_cnt_q, wake_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                 en_q, en_d;
    logic                 ack_q, ack_d;
    logic                 wk;

    assign wk = req_i | busy_i;

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            OFF: begin
                if (wk) begin
                    if (WAKE_CYCLES == 0) begin
                        state_d = ON;
                    end else begin
                        state_d    = WAKE;
                        wake_cnt_d = WAKE_W'(WAKE_CYCLES);
                    end
                end
            end
            // Leave on the last count so ack_o rises exactly WAKE_CYCLES after en_o.
            WAKE: begin
                if (wake_cnt_q <= WAKE_W'(1)) begin
                    state_d = ON;
                end else begin
                    wake_cnt_d = wake_cnt_q - WAKE_W'(1);
                end
            end
            ON: begin
                if (!wk) begin
                    if (IDLE_CYCLES <= 1) begin
                        state_d = OFF;
                    end else begin
                        state_d    = DRAIN;
                        idle_cnt_d = IDLE_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (wk) begin
                    state_d    = ON;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= IDLE_W'(IDLE_CYCLES - 1)) begin
                    state_d = OFF;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: state_d = OFF;
        endcase
    end

    // Outputs registered from next state so en_o is a clean flop output for the gate latch.
    assign en_d  = (state_d != OFF);
    assign ack_d = (state_d == ON) || (state_d == DRAIN);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            en_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            en_q       <= en_d;
            ack_q      <= ack_d;
        end
    end

    assign en_o  = en_q;
    assign te_o  = test_mode_i;
    assign ack_o = ack_q | test_mode_i;

`ifdef CLK_GATE_CTRL_STATS_EN
    // Held at zero while the gate is open, so each gated interval counts from 0.
    sat_counter #(
        .W (CNT_W)
    ) u_gated_cnt (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .clr_i   (state_q != OFF),
        .inc_i   (state_q == OFF),
        .cnt_o   (gated_cycles_o)
    );
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed scoreboard bench for clk_gate_ctrl (IDLE=4/WAKE=2 and IDLE=4/WAKE=0 instances).
module tb_clk_gate_ctrl;

    localparam int unsigned TB_CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_ni, req, busy, tm, req0;
    logic en, te, ack, en0, te0, ack0;
`ifdef CLK_GATE_CTRL_STATS_EN
    logic [TB_CNT_W-1:0] gc, gc0;
`endif

    clk_gate_ctrl #(
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2)
`ifdef CLK_GATE_CTRL_STATS_EN
        , .CNT_W     (TB_CNT_W)
`endif
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .req_i       (req),
        .busy_i      (busy),
        .test_mode_i (tm),
        .en_o        (en),
        .te_o        (te),
        .ack_o       (ack)
`ifdef CLK_GATE_CTRL_STATS_EN
        , .gated_cycles_o (gc)
`endif
    );

    clk_gate_ctrl #(
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (0)
`ifdef CLK_GATE_CTRL_STATS_EN
        , .CNT_W     (TB_CNT_W)
`endif
    ) dut0 (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .req_i       (req0),
        .busy_i      (1'b0),
        .test_mode_i (1'b0),
        .en_o        (en0),
        .te_o        (te0),
        .ack_o       (ack0)
`ifdef CLK_GATE_CTRL_STATS_EN
        , .gated_cycles_o (gc0)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic en;
        logic ack;
        logic te;
    } exp_t;

    typedef struct {
        int                  c;
        logic [TB_CNT_W-1:0] v;
    } exp_gc_t;

    exp_t    q_main[$];
    exp_t    q_w0[$];
    exp_gc_t q_gc[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic exp_main(input int a, input int b, input logic e, input logic k, input logic t);
        for (int i = a; i <= b; i++) q_main.push_back('{i, e, k, t});
    endtask

    task automatic exp_w0(input int a, input int b, input logic e, input logic k);
        for (int i = a; i <= b; i++) q_w0.push_back('{i, e, k, 1'b0});
    endtask

    task automatic exp_gc(input int c, input int v);
        q_gc.push_back('{c, TB_CNT_W'(v)});
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: mid-cycle, pop every expectation due by now; stale entries count as failures.
    always @(negedge clk) begin
        exp_t    e;
        exp_gc_t g;
        while (q_main.size() > 0 && q_main[0].c <= cyc) begin
            e = q_main.pop_front();
            n_cmp++;
            if (e.c != cyc || en !== e.en || ack !== e.ack || te !== e.te) begin
                n_fail++;
                $display("FAIL main cycle %0d (slot %0d): en/ack/te got %b%b%b want %b%b%b",
                         cyc, e.c, en, ack, te, e.en, e.ack, e.te);
            end
        end
        while (q_w0.size() > 0 && q_w0[0].c <= cyc) begin
            e = q_w0.pop_front();
            n_cmp++;
            if (e.c != cyc || en0 !== e.en || ack0 !== e.ack || te0 !== e.te) begin
                n_fail++;
                $display("FAIL wake0 cycle %0d (slot %0d): en/ack/te got %b%b%b want %b%b%b",
                         cyc, e.c, en0, ack0, te0, e.en, e.ack, e.te);
            end
        end
        while (q_gc.size() > 0 && q_gc[0].c <= cyc) begin
            g = q_gc.pop_front();
            n_cmp++;
`ifdef CLK_GATE_CTRL_STATS_EN
            if (g.c != cyc || gc !== g.v) begin
                n_fail++;
                $display("FAIL gated_cycles cycle %0d (slot %0d): got %0d want %0d", cyc, g.c, gc, g.v);
            end
`endif
        end
    end

    initial begin
        arst_ni = 1'b0;
        req     = 1'b0;
        busy    = 1'b0;
        tm      = 1'b0;
        req0    = 1'b0;

        // Reset state, held through cycle 1, released in cycle 2.
        exp_main(1, 4, 1'b0, 1'b0, 1'b0);
        exp_w0(1, 3, 1'b0, 1'b0);
        exp_w0(4, 8, 1'b1, 1'b1);
`ifdef CLK_GATE_CTRL_STATS_EN
        exp_gc(1, 0);
`endif
        goto(2);
        arst_ni = 1'b1;

        goto(3);
        req0 = 1'b1;

        // Wake: en at N+1, ack at N+1+WAKE_CYCLES.
        goto(5);
        req = 1'b1;
        exp_main(5, 5, 1'b0, 1'b0, 1'b0);
        exp_main(6, 7, 1'b1, 1'b0, 1'b0);
        exp_main(8, 19, 1'b1, 1'b1, 1'b0);

        // Close after IDLE_CYCLES idle cycles.
        goto(20);
        req = 1'b0;
        exp_main(20, 23, 1'b1, 1'b1, 1'b0);
        exp_main(24, 26, 1'b0, 1'b0, 1'b0);
`ifdef CLK_GATE_CTRL_STATS_EN
        for (int i = 0; i < 4; i++) exp_gc(24 + i, i);
`endif

        goto(27);
        req = 1'b1;
        exp_main(27, 27, 1'b0, 1'b0, 1'b0);
        exp_main(28, 29, 1'b1, 1'b0, 1'b0);
        exp_main(30, 34, 1'b1, 1'b1, 1'b0);

        // busy pulse mid-drain restarts the idle window.
        goto(35);
        req = 1'b0;
        exp_main(35, 41, 1'b1, 1'b1, 1'b0);
        exp_main(42, 42, 1'b0, 1'b0, 1'b0);
        goto(37);
        busy = 1'b1;
        goto(38);
        busy = 1'b0;

        // Request in the cycle OFF is entered: one gated cycle, then wake.
        goto(42);
        req = 1'b1;
        exp_main(43, 44, 1'b1, 1'b0, 1'b0);
        exp_main(45, 49, 1'b1, 1'b1, 1'b0);

        goto(50);
        req = 1'b0;
        exp_main(50, 53, 1'b1, 1'b1, 1'b0);
        exp_main(54, 55, 1'b0, 1'b0, 1'b0);

        // Test mode forces te/ack combinationally while the gate stays closed.
        goto(56);
        tm = 1'b1;
        exp_main(56, 56, 1'b0, 1'b1, 1'b1);
        goto(57);
        tm = 1'b0;
        exp_main(57, 59, 1'b0, 1'b0, 1'b0);

        // Async reset in the middle of WAKE.
        goto(60);
        req = 1'b1;
        exp_main(60, 60, 1'b0, 1'b0, 1'b0);
        exp_main(61, 61, 1'b1, 1'b0, 1'b0);
        goto(62);
        arst_ni = 1'b0;
        req     = 1'b0;
        exp_main(62, 66, 1'b0, 1'b0, 1'b0);
        exp_w0(62, 63, 1'b0, 1'b0);
        exp_w0(64, 66, 1'b1, 1'b1);
`ifdef CLK_GATE_CTRL_STATS_EN
        exp_gc(62, 0);
        exp_gc(63, 0);
        exp_gc(64, 1);
`endif
        goto(63);
        arst_ni = 1'b1;

        goto(68);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
